// File: rtl/simple_axi_pkg.sv
// -----------------------------------------------------------------------------
// simple_axi_pkg
// Shared definitions for the two-port simple_axi arbiter:
//   - RW codes presented on the request ports and on the master bus
//   - AXI response codes (reference for the master's error/invalid flags)
//   - arbiter FSM state encoding
//   - rw_valid(): a request is valid only for WRITE or READ (11 is reserved)
// -----------------------------------------------------------------------------
package simple_axi_pkg;

  typedef enum logic [1:0] {
    RW_NOP   = 2'b00,
    RW_WRITE = 2'b01,
    RW_READ  = 2'b10,
    RW_RSVD  = 2'b11
  } rw_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_BUSY  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DONE  = 3'd4
  } arb_state_e;

  function automatic logic rw_valid(input logic [1:0] rw);
    return (rw == RW_WRITE) || (rw == RW_READ);
  endfunction

endpackage

// File: rtl/simple_axi_arb_grant.sv
// -----------------------------------------------------------------------------
// simple_axi_arb_grant
// Combinational two-input grant.
//   valid0_i, valid1_i : port request valid
//   last_i             : index of the port granted last
//   grant_o            : some port is granted
//   idx_o              : granted port index (meaningful when grant_o = 1)
// Build option SIMPLE_AXI_ARB_FIXED_PRIO_EN: port 0 always wins ties;
// otherwise ties go to the port not granted last.
// -----------------------------------------------------------------------------
module simple_axi_arb_grant (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_i,
  output logic grant_o,
  output logic idx_o
);

  always_comb begin
    grant_o = valid0_i | valid1_i;
    idx_o   = valid1_i & ~valid0_i;
    if (valid0_i && valid1_i) begin
`ifdef SIMPLE_AXI_ARB_FIXED_PRIO_EN
      idx_o = 1'b0;
`else
      idx_o = ~last_i;
`endif
    end
  end

`ifdef SIMPLE_AXI_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last_i;
`endif

endmodule

// File: rtl/simple_axi_arbiter.sv
// -----------------------------------------------------------------------------
// simple_axi_arbiter
// Shares one simple_axi_master between two single-beat requesters.
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_reqN_addr/wdata/wsize/rw     request N operands (N = 0,1)
//   o_reqN_wait/done               pending flag, one-cycle completion pulse
//   o_reqN_rdata/error/invalid     completion data/status, held per port
//   o_m_addr/wdata/wsize/rw        to master (rw non-NOP only in ISSUE)
//   i_m_rdata/done/error/invalid   from master
//   o_m_clear_done                 tied high, master never goes done-sticky
// Build option SIMPLE_AXI_ARB_FIXED_PRIO_EN (evaluated in simple_axi_arb_grant).
//
// state | meaning
// IDLE  | arbitrate, latch winning request
// ISSUE | o_m_rw = latched rw for one cycle
// BUSY  | wait for i_m_done, latch error/invalid
// RESP  | master rdata valid, load granted port's result registers
// DONE  | done pulse on granted port
// -----------------------------------------------------------------------------
module simple_axi_arbiter
  import simple_axi_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_req0_addr,
  input  logic [63:0] i_req0_wdata,
  input  logic [2:0]  i_req0_wsize,
  input  logic [1:0]  i_req0_rw,
  output logic        o_req0_wait,
  output logic        o_req0_done,
  output logic [63:0] o_req0_rdata,
  output logic        o_req0_error,
  output logic        o_req0_invalid,
  input  logic [31:0] i_req1_addr,
  input  logic [63:0] i_req1_wdata,
  input  logic [2:0]  i_req1_wsize,
  input  logic [1:0]  i_req1_rw,
  output logic        o_req1_wait,
  output logic        o_req1_done,
  output logic [63:0] o_req1_rdata,
  output logic        o_req1_error,
  output logic        o_req1_invalid,
  output logic [31:0] o_m_addr,
  output logic [63:0] o_m_wdata,
  output logic [2:0]  o_m_wsize,
  output logic [1:0]  o_m_rw,
  input  logic [63:0] i_m_rdata,
  input  logic        i_m_done,
  input  logic        i_m_error,
  input  logic        i_m_invalid,
  output logic        o_m_clear_done
);

  arb_state_e  state_q, state_d;
  logic        last_q;
  logic        g_q;
  logic [31:0] addr_q;
  logic [63:0] wdata_q;
  logic [2:0]  wsize_q;
  logic [1:0]  m_rw_q;
  logic        m_err_q, m_inv_q;
  logic [1:0]  done_q, err_q, inv_q;
  logic [63:0] rdata0_q, rdata1_q;

  logic valid0, valid1, grant, idx;

  assign valid0 = rw_valid(i_req0_rw);
  assign valid1 = rw_valid(i_req1_rw);

  simple_axi_arb_grant u_grant (
    .valid0_i (valid0),
    .valid1_i (valid1),
    .last_i   (last_q),
    .grant_o  (grant),
    .idx_o    (idx)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (grant) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_BUSY;
      ST_BUSY:  if (i_m_done) state_d = ST_RESP;
      ST_RESP:  state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      last_q   <= 1'b1;
      g_q      <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wsize_q  <= '0;
      m_rw_q   <= RW_NOP;
      m_err_q  <= 1'b0;
      m_inv_q  <= 1'b0;
      done_q   <= '0;
      err_q    <= '0;
      inv_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      // rw and done are pulses: cleared unless set below
      m_rw_q  <= RW_NOP;
      done_q  <= '0;
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            g_q     <= idx;
            last_q  <= idx;
            addr_q  <= idx ? i_req1_addr  : i_req0_addr;
            wdata_q <= idx ? i_req1_wdata : i_req0_wdata;
            wsize_q <= idx ? i_req1_wsize : i_req0_wsize;
            m_rw_q  <= idx ? i_req1_rw    : i_req0_rw;
          end
        end
        ST_BUSY: begin
          if (i_m_done) begin
            m_err_q <= i_m_error;
            m_inv_q <= i_m_invalid;
          end
        end
        ST_RESP: begin
          // writes load rdata too; its value is don't-care for them
          if (g_q) rdata1_q <= i_m_rdata;
          else     rdata0_q <= i_m_rdata;
          err_q[g_q]  <= m_err_q;
          inv_q[g_q]  <= m_inv_q;
          done_q[g_q] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // wait drops during the port's own done cycle and is forced low in reset
  assign o_req0_wait    = i_rst_n & valid0 & ~done_q[0];
  assign o_req1_wait    = i_rst_n & valid1 & ~done_q[1];
  assign o_req0_done    = done_q[0];
  assign o_req1_done    = done_q[1];
  assign o_req0_rdata   = rdata0_q;
  assign o_req1_rdata   = rdata1_q;
  assign o_req0_error   = err_q[0];
  assign o_req1_error   = err_q[1];
  assign o_req0_invalid = inv_q[0];
  assign o_req1_invalid = inv_q[1];
  assign o_m_addr       = addr_q;
  assign o_m_wdata      = wdata_q;
  assign o_m_wsize      = wsize_q;
  assign o_m_rw         = m_rw_q;
  assign o_m_clear_done = 1'b1;

endmodule

// File: tb/tb_simple_axi_arbiter.sv
module tb_simple_axi_arbiter;

  logic        i_clk;
  logic        i_rst_n;
  logic [31:0] i_req0_addr, i_req1_addr;
  logic [63:0] i_req0_wdata, i_req1_wdata;
  logic [2:0]  i_req0_wsize, i_req1_wsize;
  logic [1:0]  i_req0_rw, i_req1_rw;
  logic        o_req0_wait, o_req0_done, o_req0_error, o_req0_invalid;
  logic        o_req1_wait, o_req1_done, o_req1_error, o_req1_invalid;
  logic [63:0] o_req0_rdata, o_req1_rdata;
  logic [31:0] o_m_addr;
  logic [63:0] o_m_wdata;
  logic [2:0]  o_m_wsize;
  logic [1:0]  o_m_rw;
  logic [63:0] i_m_rdata;
  logic        i_m_done, i_m_error, i_m_invalid;
  logic        o_m_clear_done;

  simple_axi_arbiter dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req0_addr(i_req0_addr), .i_req0_wdata(i_req0_wdata),
    .i_req0_wsize(i_req0_wsize), .i_req0_rw(i_req0_rw),
    .o_req0_wait(o_req0_wait), .o_req0_done(o_req0_done),
    .o_req0_rdata(o_req0_rdata), .o_req0_error(o_req0_error),
    .o_req0_invalid(o_req0_invalid),
    .i_req1_addr(i_req1_addr), .i_req1_wdata(i_req1_wdata),
    .i_req1_wsize(i_req1_wsize), .i_req1_rw(i_req1_rw),
    .o_req1_wait(o_req1_wait), .o_req1_done(o_req1_done),
    .o_req1_rdata(o_req1_rdata), .o_req1_error(o_req1_error),
    .o_req1_invalid(o_req1_invalid),
    .o_m_addr(o_m_addr), .o_m_wdata(o_m_wdata), .o_m_wsize(o_m_wsize),
    .o_m_rw(o_m_rw), .i_m_rdata(i_m_rdata), .i_m_done(i_m_done),
    .i_m_error(i_m_error), .i_m_invalid(i_m_invalid),
    .o_m_clear_done(o_m_clear_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // master model controls and logs
  int          m_delay = 1;
  logic [63:0] m_rdata = '0;
  logic        m_err = 1'b0;
  logic        m_inv = 1'b0;
  int          mdone_cyc = 0;
  logic [31:0] log_addr[$];
  logic [1:0]  log_rw[$];
  logic [63:0] log_wdata[$];

  // monitors
  int   rw_cycles = 0;
  int   done0_cnt = 0;
  int   done1_cnt = 0;
  logic both_done = 1'b0;
  always @(negedge i_clk) begin
    if (o_m_rw != 2'b00) rw_cycles <= rw_cycles + 1;
    if (o_req0_done) done0_cnt <= done0_cnt + 1;
    if (o_req1_done) done1_cnt <= done1_cnt + 1;
    if (o_req0_done && o_req1_done) both_done <= 1'b1;
  end

  // master: sees ISSUE, asserts done m_delay cycles later with data/status
  initial begin
    i_m_done = 1'b0; i_m_error = 1'b0; i_m_invalid = 1'b0; i_m_rdata = '0;
    forever begin
      @(negedge i_clk);
      if (o_m_rw != 2'b00) begin
        log_addr.push_back(o_m_addr);
        log_rw.push_back(o_m_rw);
        log_wdata.push_back(o_m_wdata);
        repeat (m_delay) @(negedge i_clk);
        i_m_done = 1'b1; i_m_error = m_err; i_m_invalid = m_inv;
        i_m_rdata = m_rdata;
        mdone_cyc = cyc;
        @(negedge i_clk);
        i_m_done = 1'b0; i_m_error = 1'b0; i_m_invalid = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int port, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      if ((port == 0 && o_req0_done) || (port == 1 && o_req1_done)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_any(output int port, output bit ok);
    ok = 1'b0; port = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      if (o_req0_done || o_req1_done) begin
        ok = 1'b1;
        port = o_req0_done ? 0 : 1;
        break;
      end
    end
  endtask

  bit ok;
  int p, rwc, d0, lg, base;
  logic [31:0] exp_addr[4];

  initial begin
    i_rst_n = 1'b0;
    i_req0_addr = '0; i_req0_wdata = '0; i_req0_wsize = '0; i_req0_rw = 2'b00;
    i_req1_addr = '0; i_req1_wdata = '0; i_req1_wsize = '0; i_req1_rw = 2'b00;
    repeat (3) @(negedge i_clk);
    chk("rst_m_clear_done", {63'd0, o_m_clear_done}, 64'd1);
    chk("rst_m_rw", {62'd0, o_m_rw}, 64'd0);
    chk("rst_done0", {63'd0, o_req0_done}, 64'd0);
    chk("rst_wait0", {63'd0, o_req0_wait}, 64'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // port 0 write
    i_req0_addr = 32'h1000; i_req0_wdata = 64'h1122334455667788;
    i_req0_wsize = 3'd3; i_req0_rw = 2'b01;
    rwc = rw_cycles; m_delay = 1; m_rdata = 64'h0; m_err = 0; m_inv = 0;
    #1 chk("w0_wait_pending", {63'd0, o_req0_wait}, 64'd1);
    wait_done(0, ok);
    chk("w0_done_seen", {63'd0, ok}, 64'd1);
    chk("w0_done_latency", 64'(cyc - mdone_cyc), 64'd2);
    chk("w0_error", {63'd0, o_req0_error}, 64'd0);
    chk("w0_wait_in_done", {63'd0, o_req0_wait}, 64'd0);
    chk("w0_m_wsize", {61'd0, o_m_wsize}, 64'd3);
    chk("w0_log_addr", {32'd0, log_addr[log_addr.size()-1]}, 64'h1000);
    chk("w0_log_rw", {62'd0, log_rw[log_rw.size()-1]}, 64'd1);
    chk("w0_log_wdata", log_wdata[log_wdata.size()-1], 64'h1122334455667788);
    chk("w0_rw_one_cycle", 64'(rw_cycles - rwc), 64'd1);
    i_req0_rw = 2'b00;
    @(negedge i_clk);
    chk("w0_done_one_cycle", {63'd0, o_req0_done}, 64'd0);

    // port 1 read
    d0 = done0_cnt;
    i_req1_addr = 32'h2004; i_req1_wsize = 3'd2; i_req1_rw = 2'b10;
    m_rdata = 64'hDEADBEEF;
    #1 chk("r1_wait_pending", {63'd0, o_req1_wait}, 64'd1);
    chk("r1_wait0_idle", {63'd0, o_req0_wait}, 64'd0);
    wait_done(1, ok);
    chk("r1_done_seen", {63'd0, ok}, 64'd1);
    chk("r1_rdata", o_req1_rdata, 64'hDEADBEEF);
    chk("r1_log_addr", {32'd0, log_addr[log_addr.size()-1]}, 64'h2004);
    chk("r1_log_rw", {62'd0, log_rw[log_rw.size()-1]}, 64'd2);
    i_req1_rw = 2'b00;
    repeat (3) @(negedge i_clk);
    chk("r1_rdata_held", o_req1_rdata, 64'hDEADBEEF);
    chk("r1_no_done0", 64'(done0_cnt - d0), 64'd0);

    // port 1 error + invalid, held across a port 0 completion
    i_req1_addr = 32'h3000; i_req1_rw = 2'b10;
    m_err = 1; m_inv = 1; m_rdata = 64'h55;
    wait_done(1, ok);
    chk("e1_done_seen", {63'd0, ok}, 64'd1);
    chk("e1_error", {63'd0, o_req1_error}, 64'd1);
    chk("e1_invalid", {63'd0, o_req1_invalid}, 64'd1);
    chk("e1_error0_clean", {63'd0, o_req0_error}, 64'd0);
    i_req1_rw = 2'b00;
    @(negedge i_clk);
    m_err = 0; m_inv = 0; m_rdata = 64'hA5A5;
    i_req0_addr = 32'h3100; i_req0_rw = 2'b10;
    wait_done(0, ok);
    chk("e0_done_seen", {63'd0, ok}, 64'd1);
    chk("e0_rdata", o_req0_rdata, 64'hA5A5);
    chk("e0_error0", {63'd0, o_req0_error}, 64'd0);
    chk("e0_invalid0", {63'd0, o_req0_invalid}, 64'd0);
    chk("e1_error_held", {63'd0, o_req1_error}, 64'd1);
    chk("e1_invalid_held", {63'd0, o_req1_invalid}, 64'd1);
    i_req0_rw = 2'b00;
    @(negedge i_clk);
    i_req1_addr = 32'h3200; i_req1_rw = 2'b10; m_rdata = 64'h77;
    wait_done(1, ok);
    chk("c1_done_seen", {63'd0, ok}, 64'd1);
    chk("c1_error_cleared", {63'd0, o_req1_error}, 64'd0);
    chk("c1_invalid_cleared", {63'd0, o_req1_invalid}, 64'd0);
    chk("c1_rdata", o_req1_rdata, 64'h77);
    i_req1_rw = 2'b00;
    @(negedge i_clk);

    // reserved rw is never granted
    rwc = rw_cycles; lg = log_addr.size();
    i_req0_addr = 32'h9999; i_req0_rw = 2'b11;
    #1 chk("rsvd_wait0", {63'd0, o_req0_wait}, 64'd0);
    repeat (10) @(negedge i_clk);
    chk("rsvd_no_issue", 64'(rw_cycles - rwc), 64'd0);
    chk("rsvd_no_log", 64'(log_addr.size() - lg), 64'd0);
    chk("rsvd_m_rw", {62'd0, o_m_rw}, 64'd0);
    i_req0_rw = 2'b00;
    @(negedge i_clk);

    // reset during BUSY
    m_delay = 12;
    i_req0_addr = 32'h6000; i_req0_rw = 2'b10;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      if (o_m_rw != 2'b00) begin ok = 1'b1; break; end
    end
    chk("rb_issue_seen", {63'd0, ok}, 64'd1);
    @(negedge i_clk);
    i_req1_addr = 32'h5000; i_req1_rw = 2'b10;
    i_req0_addr = 32'h4000;
    #2 i_rst_n = 1'b0;
    #1;
    chk("rb_m_clear_done", {63'd0, o_m_clear_done}, 64'd1);
    chk("rb_m_addr", {32'd0, o_m_addr}, 64'd0);
    chk("rb_m_rw", {62'd0, o_m_rw}, 64'd0);
    chk("rb_rdata0", o_req0_rdata, 64'd0);
    chk("rb_rdata1", o_req1_rdata, 64'd0);
    chk("rb_wait0", {63'd0, o_req0_wait}, 64'd0);
    chk("rb_wait1", {63'd0, o_req1_wait}, 64'd0);
    chk("rb_err_inv", {60'd0, o_req0_error, o_req0_invalid, o_req1_error, o_req1_invalid}, 64'd0);
    m_delay = 1;
    repeat (20) @(negedge i_clk);
    base = log_addr.size();
    i_rst_n = 1'b1;

    // continuous tie from reset
`ifdef SIMPLE_AXI_ARB_FIXED_PRIO_EN
    exp_addr[0] = 32'h4000; exp_addr[1] = 32'h4000;
    exp_addr[2] = 32'h4000; exp_addr[3] = 32'h4000;
`else
    exp_addr[0] = 32'h4000; exp_addr[1] = 32'h5000;
    exp_addr[2] = 32'h4000; exp_addr[3] = 32'h5000;
`endif
    for (int k = 0; k < 4; k++) begin
      wait_any(p, ok);
      chk($sformatf("tie_done_seen_%0d", k), {63'd0, ok}, 64'd1);
      if (k == 0) begin
        chk("tie_first_port0", 64'(p), 64'd0);
        chk("tie_wait1_other", {63'd0, o_req1_wait}, 64'd1);
      end
    end
    i_req0_rw = 2'b00; i_req1_rw = 2'b00;
    repeat (3) @(negedge i_clk);
    chk("tie_log_count", 64'(log_addr.size() - base), 64'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("tie_grant_%0d", k),
          (base + k < log_addr.size()) ? {32'd0, log_addr[base+k]} : 64'hFFFF_FFFF_FFFF_FFFF,
          {32'd0, exp_addr[k]});
    end
    chk("never_both_done", {63'd0, both_done}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/simple_axi_arbiter.md
# simple_axi_arbiter

Two-port arbiter that shares one `simple_axi_master` between two requesters, e.g. instruction fetch on port 0 and load/store on port 1. It accepts single-beat read/write requests on each port, grants one at a time, and drives the master's internal bus for that request. It returns read data and status to the granted port. It keeps the master in plain idle by holding `o_m_clear_done` high, so the master's done-sticky state is never entered.

## Interface
- No parameters.
- `i_clk` in 1: global clock
- `i_rst_n` in 1: asynchronous active-low reset
- `i_reqN_addr` in 32, N=0,1: request address
- `i_reqN_wdata` in 64: write data, right-aligned
- `i_reqN_wsize` in 3: 0=byte, 1=half, 2=word, 3=dword
- `i_reqN_rw` in 2: 00=idle, 01=write, 10=read, 11=reserved
- `o_reqN_wait` out 1: request pending, not yet done
- `o_reqN_done` out 1: one-cycle completion pulse
- `o_reqN_rdata` out 64: read data, held until the next completion on this port
- `o_reqN_error` out 1: bresp/rresp ≠ OKAY, held like rdata
- `o_reqN_invalid` out 1: resp = DECERR, held like rdata
- `o_m_addr` out 32, `o_m_wdata` out 64, `o_m_wsize` out 3, `o_m_rw` out 2: to master
- `i_m_rdata` in 64, `i_m_done` in 1, `i_m_error` in 1, `i_m_invalid` in 1: from master
- `o_m_clear_done` out 1: constant 1

## Operation
- FSM states:
  - IDLE: arbitrate, described below.
  - ISSUE: drive latched request on `o_m_*` with `o_m_rw` = latched rw for exactly this cycle → BUSY.
  - BUSY: `o_m_rw`=00; on `i_m_done` latch `i_m_error` and `i_m_invalid` → RESP.
  - RESP: master read data is now valid; load `o_gN_rdata`, `o_gN_error` and `o_gN_invalid` for the granted port g → DONE.
  - DONE: `o_gN_done`=1 → IDLE.
- Arbitration in IDLE:
  - Valid request: `i_reqN_rw` ∈ {01,10}. A value of 11 is ignored and never granted.
  - If exactly one port is valid, grant it.
  - If both are valid, grant the port not granted last. `r_last` resets to 1, so port 0 wins the first tie.
  - On grant, latch addr, wdata, wsize and rw into internal registers, record g, and go to ISSUE.
- `o_m_addr`, `o_m_wdata` and `o_m_wsize` are driven from the latched registers in every state. `o_m_rw` is non-00 only in ISSUE.
- Write requests also perform the RESP register load. `o_gN_rdata` is then loaded with whatever the master presents; it is don't-care for writes.
- `o_reqN_wait` is combinational:
  - 1 while `i_reqN_rw` is valid and the port is not in its DONE cycle.
  - The non-granted port sees `o_reqN_wait`=1 throughout the other port's transaction.
- Requester rules:
  - Hold rw and operands stable from assertion until `o_reqN_done` is sampled high.
  - At that edge, change or drop rw. A valid rw in the following IDLE cycle is a new request.
  - Operand changes while pending are ignored after the grant (they are latched at grant).
- Reset, asynchronous at any time:
  - FSM → IDLE, `r_last`=1.
  - All `o_reqN_*` outputs 0, all `o_m_*` outputs 0 except `o_m_clear_done`=1.
  - The system resets the master in the same event. The arbiter does not recover an in-flight transaction.

## Timing
- Cycle t: IDLE with valid request. t+1: ISSUE, master captures. t+2: master SET_ADDR.
- Let the master assert `i_m_done` in cycle d. RESP is d+1, DONE with done pulse is d+2, IDLE is d+3.
- Minimum inter-grant gap: a new grant is possible at d+3.
- `o_reqN_done` is high for exactly one cycle per accepted request and never on both ports in the same cycle.
- Data, error and invalid are valid in the done cycle and held afterwards.

## Configuration
- `SIMPLE_AXI_ARB_FIXED_PRIO_EN` defined: port 0 always wins ties. `r_last` is still maintained but unused.
- Undefined (default): round-robin tie-break as described in Operation.

## Structure
- `simple_axi_pkg` holds:
  - RW codes (NOP/WRITE/READ)
  - RESP codes
  - arbiter state encodings (IDLE=0, ISSUE=1, BUSY=2, RESP=3, DONE=4, 3 bits)
- Sub-module `simple_axi_arb_grant`: combinational two-input grant from valid0, valid1 and last, returning grant and index. The macro is evaluated there.

## Test plan
- Port 0 write 0x1122334455667788 to 0x1000 with wsize 3; master done at d → `o_req0_done` at d+2, error=0; master sees `o_m_rw`=01 for exactly one cycle.
- Port 1 read of 0x2004 with wsize 2; master data 0xDEADBEEF → `o_req1_rdata`=0xDEADBEEF in the done cycle, `o_req0_done` never asserted.
- Both ports request continuously from reset, default build → grants 0,1,0,1; with `SIMPLE_AXI_ARB_FIXED_PRIO_EN` → 0,0,0 (port 1 starved).
- Master returns error=1, invalid=1 for port 1 → `o_req1_error`=1 and `o_req1_invalid`=1 held until the next port 1 completion; port 0 status unchanged.
- `i_req0_rw`=11 held, port 1 idle → no grant, `o_m_rw` stays 00, `o_req0_wait`=0.
- `i_rst_n` low during BUSY → all outputs 0 asynchronously, `o_m_clear_done`=1; after release, first tie goes to port 0.
